trivium_prng_stream: RTL and testbench

Parametrised successor to the team's unrolled Trivium PRNG: a self-initialising keystream source with a seed handshake, automatic warm-up and a registered, glitch-free output behind a valid/ready stream interface. It advances RND Trivium steps per cycle. It feeds randomness consumers in the masked AES datapath, which no longer sequence feed/update or count warm-up shifts themselves.

---
 rtl/trivium_prng_stream.sv | 129 ++++++++++++
 tb/tb_trivium_prng_stream.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_prng_stream.sv
// Trivium keystream source with seed handshake, automatic warm-up and a registered
// valid/ready output. Advances RND chained Trivium steps per state update.
module trivium_prng_stream #(
    parameter int RND           = 1,
    parameter int WARMUP_SHIFTS = 1152
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [79:0]    in_key,
    input  logic [79:0]    in_iv,
    input  logic           in_seed_valid,
    output logic           in_seed_ready,
    output logic [RND-1:0] out_rnd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);

    // Handshakes: a seed transfers on a rising edge where in_seed_valid and
    // in_seed_ready are both high; a word transfers where out_valid and out_ready are.
    localparam int W  = (WARMUP_SHIFTS + RND - 1) / RND;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [287:0]    triv_q, triv_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RND-1:0]  rnd_q, rnd_d;
    logic            valid_q, valid_d;

    logic [287:0]    upd_s;
    logic [RND-1:0]  upd_z;
    logic [287:0]    seed_s;
    logic            seed_fire;
    logic            t1, t2, t3, n1, n94, n178;

    // Bit k of triv_q holds Trivium s(k+1); one update chains RND steps.
    always_comb begin
        upd_s = triv_q;
        upd_z = '0;
        t1    = 1'b0;
        t2    = 1'b0;
        t3    = 1'b0;
        n1    = 1'b0;
        n94   = 1'b0;
        n178  = 1'b0;
        for (int i = 0; i < RND; i++) begin
            t1       = upd_s[65] ^ upd_s[92];
            t2       = upd_s[161] ^ upd_s[176];
            t3       = upd_s[242] ^ upd_s[287];
            upd_z[i] = t1 ^ t2 ^ t3;
            n1       = t3 ^ (upd_s[285] & upd_s[286]) ^ upd_s[68];
            n94      = t1 ^ (upd_s[90] & upd_s[91]) ^ upd_s[170];
            n178     = t2 ^ (upd_s[174] & upd_s[175]) ^ upd_s[263];
            upd_s    = {upd_s[286:177], n178, upd_s[175:93], n94, upd_s[91:0], n1};
        end
    end

    assign seed_s    = {3'b111, 112'd0, in_iv, 13'd0, in_key};
    assign seed_fire = in_seed_valid && (state_q != ST_WARMUP);

    always_comb begin
        state_d = state_q;
        triv_d  = triv_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        valid_d = valid_q;
        case (state_q)
            ST_UNSEEDED: begin
                if (seed_fire) begin
                    triv_d  = seed_s;
                    cnt_d   = '0;
                    state_d = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                triv_d = upd_s;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A reseed wins over any output load; the pending word is dropped.
                if (seed_fire) begin
                    triv_d  = seed_s;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    state_d = ST_WARMUP;
                end else if (!valid_q || out_ready) begin
                    triv_d  = upd_s;
                    rnd_d   = upd_z;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_UNSEEDED;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_UNSEEDED;
            triv_q  <= '0;
            cnt_q   <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            triv_q  <= triv_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
        end
    end

    assign out_rnd       = rnd_q;
    assign out_valid     = valid_q;
    assign busy          = (state_q == ST_WARMUP);
    assign in_seed_ready = (state_q != ST_WARMUP);

endmodule

// File: tb/tb_trivium_prng_stream.sv
// Bench for trivium_prng_stream: an RND=64 and an RND=1 instance checked against a
// bit-serial Trivium reference model.
module tb_trivium_prng_stream;

    localparam int W64 = 18;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [79:0] in_key, in_iv;
    logic        sv64, sv1, rdy64, rdy1;
    logic        sr64, sr1, vld64, vld1, busy64, busy1;
    logic [63:0] rnd64;
    logic [0:0]  rnd1;

    int n_cmp = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    trivium_prng_stream #(.RND(64), .WARMUP_SHIFTS(1152)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_key(in_key), .in_iv(in_iv),
        .in_seed_valid(sv64), .in_seed_ready(sr64), .out_rnd(rnd64),
        .out_valid(vld64), .out_ready(rdy64), .busy(busy64)
    );

    trivium_prng_stream #(.RND(1), .WARMUP_SHIFTS(1152)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_key(in_key), .in_iv(in_iv),
        .in_seed_valid(sv1), .in_seed_ready(sr1), .out_rnd(rnd1),
        .out_valid(vld1), .out_ready(rdy1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] rand80();
        return {$urandom(), $urandom(), 16'($urandom())};
    endfunction

    // Reference: discard 1152 steps, then pack keystream bits LSB-first into words.
    task automatic model_fill(input logic [79:0] k, input logic [79:0] v, input int nwords);
        bit s[1:288];
        bit t1, t2, t3, n1, n94, n178;
        logic [63:0] w;
        int j;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[i-1];
            s[93 + i] = v[i-1];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        exp_q.delete();
        w = '0;
        for (int n = 0; n < 1152 + nwords * 64; n++) begin
            t1   = s[66] ^ s[93];
            t2   = s[162] ^ s[177];
            t3   = s[243] ^ s[288];
            n1   = t3 ^ (s[286] & s[287]) ^ s[69];
            n94  = t1 ^ (s[91] & s[92]) ^ s[171];
            n178 = t2 ^ (s[175] & s[176]) ^ s[264];
            for (int i = 288; i >= 2; i--) s[i] = s[i-1];
            s[1] = n1; s[94] = n94; s[178] = n178;
            if (n >= 1152) begin
                j = (n - 1152) % 64;
                w[j] = t1 ^ t2 ^ t3;
                if (j == 63) exp_q.push_back(w);
            end
        end
    endtask

    task automatic do_seed(input bit use64, input bit use1, input logic [79:0] k,
                           input logic [79:0] v);
        int waited = 0;
        while (((use64 && !sr64) || (use1 && !sr1)) && waited < 2000) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (waited >= 2000) begin
            n_fail++;
            $display("FAIL seed_wait: in_seed_ready low for %0d cycles, want high", waited);
        end
        in_key = k; in_iv = v; sv64 = use64; sv1 = use1;
        tick();
        sv64 = 1'b0; sv1 = 1'b0;
    endtask

    // Called just after the seed edge E0.
    task automatic warmup_check(input string name);
        for (int c = 0; c < W64; c++) begin
            n_cmp++;
            if ({busy64, sr64, vld64} !== 3'b100) begin
                n_fail++;
                $display("FAIL %s_warm c=%0d: busy/ready/valid=%b want 100", name, c,
                         {busy64, sr64, vld64});
            end
            tick();
        end
        n_cmp++;
        if ({busy64, sr64, vld64} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s_run: busy/ready/valid=%b want 010", name, {busy64, sr64, vld64});
        end
        tick();
        n_cmp++;
        if (vld64 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_first_valid: out_valid=%b want 1 at %0d cycles", name, vld64, W64 + 1);
        end
    endtask

    task automatic drain_check(input string name, input int n, input bit bp);
        int got = 0;
        int cyc = 0;
        logic pv = 1'b0, pr = 1'b0;
        logic [63:0] prnd = '0;
        logic [63:0] e;
        while (got < n && cyc < n * 8 + 200) begin
            rdy64 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pv && !pr) begin
                n_cmp++;
                if ({vld64, rnd64} !== {1'b1, prnd}) begin
                    n_fail++;
                    $display("FAIL %s_hold: valid=%b rnd=%h want 1 %h", name, vld64, rnd64, prnd);
                end
            end else if (pv) begin
                n_cmp++;
                if (vld64 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_valid_drop: out_valid=%b want 1", name, vld64);
                end
            end
            if (vld64 && rdy64) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_cmp++;
                if (rnd64 !== e) begin
                    n_fail++;
                    $display("FAIL %s_word %0d: got %h want %h", name, got, rnd64, e);
                end
                got++;
            end
            pv = vld64; pr = rdy64; prnd = rnd64;
            tick();
            cyc++;
        end
        n_cmp++;
        if (got != n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d words want %0d", name, got, n);
        end
        rdy64 = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sv64 = 1'b0; sv1 = 1'b0; rdy64 = 1'b0; rdy1 = 1'b0;
        in_key = '0; in_iv = '0;
        repeat (3) tick();
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if ({sr64, busy64, vld64, rnd64} !== {3'b100, 64'd0}) begin
                n_fail++;
                $display("FAIL reset64 p=%0d: rdy/busy/vld/rnd=%b%b%b %h want 100 0", p,
                         sr64, busy64, vld64, rnd64);
            end
            n_cmp++;
            if ({sr1, busy1, vld1, rnd1} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset1 p=%0d: rdy/busy/vld/rnd=%b want 1000", p,
                         {sr1, busy1, vld1, rnd1});
            end
            rst_n = 1'b1;
            tick();
        end
    endtask

    task automatic test_warmup_latency();
        rdy64 = 1'b1;
        do_seed(1'b1, 1'b0, 80'd0, 80'd0);
        warmup_check("zero_seed");
        model_fill(80'd0, 80'd0, 32);
        drain_check("zero_seed", 32, 1'b0);
    endtask

    task automatic test_stream_equiv();
        logic [79:0] k = rand80();
        logic [79:0] v = rand80();
        logic [63:0] ref1_q[$];
        logic [63:0] acc = '0;
        logic [63:0] e;
        int c = 0, got64 = 0, got1 = 0, nb = 0, first1 = -1;
        rdy64 = 1'b1; rdy1 = 1'b1;
        do_seed(1'b1, 1'b1, k, v);
        model_fill(k, v, 64);
        ref1_q = exp_q;
        while ((got64 < 64 || got1 < 64) && c < 6000) begin
            if (vld1 && first1 < 0) first1 = c;
            if (vld64 && got64 < 64) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (rnd64 !== e) begin
                    n_fail++;
                    $display("FAIL equiv64_word %0d: got %h want %h", got64, rnd64, e);
                end
                got64++;
            end
            if (vld1 && got1 < 64) begin
                acc[nb] = rnd1[0];
                nb++;
                if (nb == 64) begin
                    e = ref1_q.pop_front();
                    n_cmp++;
                    if (acc !== e) begin
                        n_fail++;
                        $display("FAIL equiv1_word %0d: got %h want %h", got1, acc, e);
                    end
                    got1++;
                    nb = 0;
                end
            end
            tick();
            c++;
        end
        n_cmp++;
        if (first1 != 1153) begin
            n_fail++;
            $display("FAIL equiv1_latency: first valid at %0d cycles want 1153", first1);
        end
        n_cmp++;
        if (got64 != 64 || got1 != 64) begin
            n_fail++;
            $display("FAIL equiv_count: got %0d/%0d words want 64/64", got64, got1);
        end
    endtask

    task automatic test_back_pressure();
        logic [79:0] k = rand80();
        logic [79:0] v = rand80();
        do_seed(1'b1, 1'b0, k, v);
        model_fill(k, v, 120);
        drain_check("bp", 120, 1'b1);
    endtask

    task automatic test_reseed_run();
        logic [79:0] ka = rand80(), va = rand80(), kb = rand80(), vb = rand80();
        do_seed(1'b1, 1'b0, ka, va);
        model_fill(ka, va, 8);
        drain_check("reseed_pre", 4, 1'b0);
        rdy64 = 1'b1;
        n_cmp++;
        if ({vld64, sr64} !== 2'b11) begin
            n_fail++;
            $display("FAIL reseed_ready: valid/seed_ready=%b want 11", {vld64, sr64});
        end
        in_key = kb; in_iv = vb; sv64 = 1'b1;
        tick();
        sv64 = 1'b0;
        warmup_check("reseed");
        model_fill(kb, vb, 16);
        drain_check("reseed_post", 16, 1'b0);
    endtask

    task automatic test_seed_in_warmup();
        logic [79:0] ka = rand80(), va = rand80(), kb = rand80(), vb = rand80();
        do_seed(1'b1, 1'b0, ka, va);
        model_fill(ka, va, 16);
        repeat (2) tick();
        in_key = kb; in_iv = vb; sv64 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (sr64 !== 1'b0) begin
                n_fail++;
                $display("FAIL warm_seed_ready c=%0d: in_seed_ready=%b want 0", c, sr64);
            end
            tick();
        end
        sv64 = 1'b0;
        drain_check("warm_ignore", 16, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [79:0] k, v;
        for (int p = 0; p < 2; p++) begin
            k = rand80(); v = rand80();
            do_seed(1'b1, 1'b0, k, v);
            if (p == 0) begin
                repeat (5) tick();
            end else begin
                model_fill(k, v, 8);
                drain_check("rst_pre", 5, 1'b0);
            end
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            n_cmp++;
            if ({sr64, busy64, vld64, rnd64} !== {3'b100, 64'd0}) begin
                n_fail++;
                $display("FAIL rst_mid64 p=%0d: rdy/busy/vld=%b rnd=%h want 100 0", p,
                         {sr64, busy64, vld64}, rnd64);
            end
            n_cmp++;
            if ({sr1, busy1, vld1, rnd1} !== 4'b1000) begin
                n_fail++;
                $display("FAIL rst_mid1 p=%0d: rdy/busy/vld/rnd=%b want 1000", p,
                         {sr1, busy1, vld1, rnd1});
            end
            for (int c = 0; c < 30; c++) begin
                n_cmp++;
                if ({sr64, busy64, vld64} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL rst_idle p=%0d c=%0d: rdy/busy/vld=%b want 100", p, c,
                             {sr64, busy64, vld64});
                end
                tick();
            end
        end
        k = rand80(); v = rand80();
        do_seed(1'b1, 1'b0, k, v);
        warmup_check("rst_fresh");
        model_fill(k, v, 8);
        drain_check("rst_fresh", 8, 1'b0);
    endtask

    initial begin
        test_reset();
        test_warmup_latency();
        test_stream_equiv();
        test_back_pressure();
        test_reseed_run();
        test_seed_in_warmup();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
